// File: rtl/hwcounter_reader_pkg.sv
// Shared types and constants for the tear-free 64-bit hardware counter reader.
package hwcounter_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_AR_HI1 = 3'd1,
        ST_R_HI1  = 3'd2,
        ST_AR_LO  = 3'd3,
        ST_R_LO   = 3'd4,
        ST_AR_HI2 = 3'd5,
        ST_R_HI2  = 3'd6,
        ST_OUT    = 3'd7
    } state_t;

    // Byte offsets of the counter words inside the counter slave.
    localparam logic [31:0] LO_OFFSET = 32'h0000_0000;
    localparam logic [31:0] HI_OFFSET = 32'h0000_0004;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Width of the retry counter; never narrower than one bit.
    function automatic int retry_cnt_w(input int max_retries);
        int w;
        w = $clog2(max_retries + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hwcounter_reader.sv
// AXI4-Lite read master returning one tear-free 64-bit timestamp per request,
// using a hi-lo-hi read sequence with a bounded number of lo/hi re-reads.
module hwcounter_reader
    import hwcounter_reader_pkg::*;
#(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_COUNTER_BASE     = '0,
    parameter int                            C_MAX_RETRIES      = 3
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            req_valid,
    output logic                            req_ready,
    output logic                            ts_valid,
    input  logic                            ts_ready,
    output logic [2*C_M_AXI_DATA_WIDTH-1:0] ts_data,
    output logic                            ts_error,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready
);

    localparam int DW      = C_M_AXI_DATA_WIDTH;
    localparam int AW      = C_M_AXI_ADDR_WIDTH;
    localparam int RETRY_W = retry_cnt_w(C_MAX_RETRIES);

    localparam logic [AW-1:0]      ADDR_LO   = C_COUNTER_BASE + AW'(LO_OFFSET);
    localparam logic [AW-1:0]      ADDR_HI   = C_COUNTER_BASE + AW'(HI_OFFSET);
    localparam logic [RETRY_W-1:0] MAX_RETRY = RETRY_W'(C_MAX_RETRIES);

    state_t               r_state;
    state_t               w_state_nxt;

    logic [DW-1:0]        r_hi1;
    logic [DW-1:0]        r_lo;
    logic [RETRY_W-1:0]   r_retry;

    logic                 r_req_ready;
    logic                 r_ts_valid;
    logic [2*DW-1:0]      r_ts_data;
    logic                 r_ts_error;
    logic [AW-1:0]        r_araddr;
    logic                 r_arvalid;
    logic                 r_rready;

    logic                 w_ts_load;
    logic [2*DW-1:0]      w_ts_data_nxt;
    logic                 w_ts_err_nxt;
    logic                 w_retry_inc;
    logic                 w_resp_err;
    logic                 w_next_is_ar_hi;
    logic                 w_next_is_r;

    assign req_ready     = r_req_ready;
    assign ts_valid      = r_ts_valid;
    assign ts_data       = r_ts_data;
    assign ts_error      = r_ts_error;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

    assign w_resp_err      = (m_axi_rresp != AXI_RESP_OKAY);
    assign w_next_is_ar_hi = (w_state_nxt == ST_AR_HI1) || (w_state_nxt == ST_AR_HI2);
    assign w_next_is_r     = (w_state_nxt == ST_R_HI1) || (w_state_nxt == ST_R_LO) ||
                             (w_state_nxt == ST_R_HI2);

    // State register; reset wins over any handshake in flight.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, timestamp load decision and retry bookkeeping.
    always_comb begin
        w_state_nxt   = r_state;
        w_ts_load     = 1'b0;
        w_ts_data_nxt = '0;
        w_ts_err_nxt  = 1'b0;
        w_retry_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_state_nxt = ST_AR_HI1;
                end
            end
            ST_AR_HI1: if (m_axi_arready) w_state_nxt = ST_R_HI1;
            ST_AR_LO:  if (m_axi_arready) w_state_nxt = ST_R_LO;
            ST_AR_HI2: if (m_axi_arready) w_state_nxt = ST_R_HI2;
            ST_R_HI1, ST_R_LO: begin
                if (m_axi_rvalid) begin
                    if (w_resp_err) begin
                        w_state_nxt  = ST_OUT;
                        w_ts_load    = 1'b1;
                        w_ts_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = (r_state == ST_R_HI1) ? ST_AR_LO : ST_AR_HI2;
                    end
                end
            end
            ST_R_HI2: begin
                if (m_axi_rvalid) begin
                    if (w_resp_err) begin
                        w_state_nxt  = ST_OUT;
                        w_ts_load    = 1'b1;
                        w_ts_err_nxt = 1'b1;
                    end else if (r_hi1 == m_axi_rdata) begin
                        w_state_nxt   = ST_OUT;
                        w_ts_load     = 1'b1;
                        w_ts_data_nxt = {m_axi_rdata, r_lo};
                    end else if (r_retry < MAX_RETRY) begin
                        // High word moved between reads: re-read lo and hi again.
                        w_state_nxt = ST_AR_LO;
                        w_retry_inc = 1'b1;
                    end else begin
                        w_state_nxt   = ST_OUT;
                        w_ts_load     = 1'b1;
                        w_ts_data_nxt = {m_axi_rdata, r_lo};
                        w_ts_err_nxt  = 1'b1;
                    end
                end
            end
            ST_OUT: begin
                if (ts_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs decoded from the next state, plus timestamp and retry counter.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_req_ready <= 1'b0;
            r_ts_valid  <= 1'b0;
            r_ts_data   <= '0;
            r_ts_error  <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_retry     <= '0;
        end else begin
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_ts_valid  <= (w_state_nxt == ST_OUT);
            r_arvalid   <= w_next_is_ar_hi || (w_state_nxt == ST_AR_LO);
            r_rready    <= w_next_is_r;
            if (w_next_is_ar_hi) begin
                r_araddr <= ADDR_HI;
            end else if (w_state_nxt == ST_AR_LO) begin
                r_araddr <= ADDR_LO;
            end
            if (w_ts_load) begin
                r_ts_data  <= w_ts_data_nxt;
                r_ts_error <= w_ts_err_nxt;
            end
            if (w_retry_inc) begin
                r_retry <= r_retry + 1'b1;
            end else if ((r_state == ST_OUT) && ts_ready) begin
                r_retry <= '0;
            end
        end
    end

    // Capture of the counter words; a retry promotes the latest hi read to hi1.
    always_ff @(posedge aclk) begin
        if (m_axi_rvalid && (r_state == ST_R_HI1)) begin
            r_hi1 <= m_axi_rdata;
        end else if (w_retry_inc) begin
            r_hi1 <= m_axi_rdata;
        end
        if (m_axi_rvalid && (r_state == ST_R_LO)) begin
            r_lo <= m_axi_rdata;
        end
    end

endmodule

// File: tb/tb_hwcounter_reader.sv
// Self-checking bench for hwcounter_reader against a scripted counter slave model.
module tb_hwcounter_reader;

    logic        aclk;
    logic        areset;
    logic        req_valid;
    logic        req_ready;
    logic        ts_valid;
    logic        ts_ready;
    logic [63:0] ts_data;
    logic        ts_error;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    hwcounter_reader dut (
        .aclk          (aclk),
        .areset        (areset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .ts_valid      (ts_valid),
        .ts_ready      (ts_ready),
        .ts_data       (ts_data),
        .ts_error      (ts_error),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        int              n_rsp;
        logic [8:0][31:0] d;
        logic [8:0][1:0]  r;
        logic [63:0]     exp_data;
        logic            exp_err;
        int              exp_lat;
        int              exp_nar;
    } vec_t;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
        int          lat;
        int          nar;
    } exp_t;

    vec_t        vecs [5];
    exp_t        sb_q [$];
    logic [33:0] rsp_q [$];
    logic [31:0] ar_log [$];
    logic [31:0] dflt_hi;
    logic [31:0] dflt_lo;
    logic [33:0] pop_rsp;

    int n_total;
    int n_pass;

    // Counter slave: arready one cycle after arvalid, rvalid one cycle after the AR handshake.
    always @(posedge aclk) begin
        if (areset) begin
            m_axi_arready <= 1'b0;
            m_axi_rvalid  <= 1'b0;
        end else begin
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
            if (m_axi_arvalid && m_axi_arready) begin
                m_axi_arready <= 1'b0;
                ar_log.push_back(m_axi_araddr);
                if (rsp_q.size() > 0) begin
                    pop_rsp = rsp_q.pop_front();
                end else begin
                    pop_rsp = {2'b00, (m_axi_araddr == 32'h4) ? dflt_hi : dflt_lo};
                end
                m_axi_rdata  <= pop_rsp[31:0];
                m_axi_rresp  <= pop_rsp[33:32];
                m_axi_rvalid <= 1'b1;
            end else if (m_axi_arvalid && !m_axi_rvalid) begin
                m_axi_arready <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_ts_valid"}, 64'(ts_valid), 64'd0);
        chk({tag, "_ts_data"}, ts_data, 64'd0);
        chk({tag, "_ts_error"}, 64'(ts_error), 64'd0);
        chk({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'd0);
        chk({tag, "_araddr"}, 64'(m_axi_araddr), 64'd0);
        chk({tag, "_rready"}, 64'(m_axi_rready), 64'd0);
    endtask

    // Waits for req_ready, then holds req_valid through one handshake edge; returns in cycle 1.
    task automatic issue_req();
        int guard;
        guard = 0;
        @(negedge aclk);
        while (!req_ready && guard < 50) begin
            @(negedge aclk);
            guard++;
        end
        if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        @(posedge aclk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_ts(input int start, output int lat);
        lat = start;
        while (!ts_valid && lat < 200) begin
            @(posedge aclk);
            #1;
            lat++;
        end
        if (!ts_valid) chk("ts_valid_timeout", 64'(ts_valid), 64'd1);
    endtask

    task automatic check_ts(input int lat);
        exp_t e;
        bit   order_ok;
        e = sb_q.pop_front();
        chk("ts_data", ts_data, e.data);
        chk("ts_error", 64'(ts_error), 64'(e.err));
        chk("ts_latency", 64'(lat), 64'(e.lat));
        chk("ar_count", 64'(ar_log.size()), 64'(e.nar));
        order_ok = 1'b1;
        for (int i = 0; i < ar_log.size(); i++) begin
            if (ar_log[i] !== ((i == 0 || (i % 2) == 0) ? 32'h4 : 32'h0)) order_ok = 1'b0;
        end
        chk("araddr_order", 64'(order_ok), 64'd1);
    endtask

    task automatic accept_ts();
        ts_ready = 1'b1;
        @(posedge aclk);
        #1;
        ts_ready = 1'b0;
        chk("ts_valid_drop", 64'(ts_valid), 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        rsp_q.delete();
        ar_log.delete();
        for (int i = 0; i < v.n_rsp; i++) rsp_q.push_back({v.r[i], v.d[i]});
        sb_q.push_back({v.exp_data, v.exp_err, v.exp_lat, v.exp_nar});
        issue_req();
        wait_ts(1, lat);
        check_ts(lat);
        accept_ts();
    endtask

    initial begin
        logic [63:0] held;
        int          lat;
        int          guard;

        n_total   = 0;
        n_pass    = 0;
        areset    = 1'b1;
        req_valid = 1'b0;
        ts_ready  = 1'b0;
        dflt_hi   = 32'h1;
        dflt_lo   = 32'h10;

        vecs[0] = '0;
        vecs[0].n_rsp = 3;
        vecs[0].d[0] = 32'h1; vecs[0].d[1] = 32'h10; vecs[0].d[2] = 32'h1;
        vecs[0].exp_data = 64'h00000001_00000010; vecs[0].exp_err = 1'b0;
        vecs[0].exp_lat = 10; vecs[0].exp_nar = 3;

        vecs[1] = '0;
        vecs[1].n_rsp = 5;
        vecs[1].d[0] = 32'h1; vecs[1].d[1] = 32'hFFFF_FFFE; vecs[1].d[2] = 32'h2;
        vecs[1].d[3] = 32'h3; vecs[1].d[4] = 32'h2;
        vecs[1].exp_data = 64'h00000002_00000003; vecs[1].exp_err = 1'b0;
        vecs[1].exp_lat = 16; vecs[1].exp_nar = 5;

        vecs[2] = '0;
        vecs[2].n_rsp = 9;
        vecs[2].d[0] = 32'h1; vecs[2].d[1] = 32'hA0; vecs[2].d[2] = 32'h2;
        vecs[2].d[3] = 32'hA1; vecs[2].d[4] = 32'h3; vecs[2].d[5] = 32'hA2;
        vecs[2].d[6] = 32'h4; vecs[2].d[7] = 32'hA3; vecs[2].d[8] = 32'h5;
        vecs[2].exp_data = 64'h00000005_000000A3; vecs[2].exp_err = 1'b1;
        vecs[2].exp_lat = 28; vecs[2].exp_nar = 9;

        vecs[3] = '0;
        vecs[3].n_rsp = 2;
        vecs[3].d[0] = 32'h1; vecs[3].d[1] = 32'h55; vecs[3].r[1] = 2'b10;
        vecs[3].exp_data = 64'h0; vecs[3].exp_err = 1'b1;
        vecs[3].exp_lat = 7; vecs[3].exp_nar = 2;

        vecs[4] = '0;
        vecs[4].n_rsp = 1;
        vecs[4].d[0] = 32'h9; vecs[4].r[0] = 2'b11;
        vecs[4].exp_data = 64'h0; vecs[4].exp_err = 1'b1;
        vecs[4].exp_lat = 4; vecs[4].exp_nar = 1;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk_reset_outputs("reset");
        @(negedge aclk);
        areset = 1'b0;

        // Table-driven transactions
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Backpressure in OUT with req_valid held high, then back-to-back request
        rsp_q.delete();
        ar_log.delete();
        sb_q.push_back({64'h00000001_00000010, 1'b0, 10, 3});
        issue_req();
        req_valid = 1'b1;
        wait_ts(1, lat);
        check_ts(lat);
        held = ts_data;
        for (int k = 0; k < 5; k++) begin
            @(posedge aclk);
            #1;
            chk("bp_ts_data", ts_data, held);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_arvalid", 64'(m_axi_arvalid), 64'd0);
        end
        ts_ready = 1'b1;
        @(posedge aclk);
        #1;
        ts_ready = 1'b0;
        ar_log.delete();
        sb_q.push_back({64'h00000001_00000010, 1'b0, 10, 3});
        chk("idle_req_ready", 64'(req_ready), 64'd1);
        chk("idle_ts_valid", 64'(ts_valid), 64'd0);
        @(posedge aclk);
        #1;
        req_valid = 1'b0;
        chk("b2b_arvalid", 64'(m_axi_arvalid), 64'd1);
        wait_ts(1, lat);
        check_ts(lat);
        accept_ts();

        // Reset during R_LO, then a normal transaction
        rsp_q.delete();
        ar_log.delete();
        issue_req();
        guard = 0;
        while (!(m_axi_rready && ar_log.size() == 2) && guard < 50) begin
            @(posedge aclk);
            #1;
            guard++;
        end
        chk("reach_r_lo", 64'(m_axi_rready && ar_log.size() == 2), 64'd1);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        chk_reset_outputs("midreset");
        areset = 1'b0;
        rsp_q.delete();
        ar_log.delete();
        vecs[0].d[0] = 32'h5; vecs[0].d[1] = 32'h77; vecs[0].d[2] = 32'h5;
        vecs[0].exp_data = 64'h00000005_00000077;
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
